chip_74161_emu: RTL and testbench
=================================

CHIP_74161_EMU -- requirements
Module: chip_74161_emu

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous active-low reset.
REQ-004 Pin1  input  1  CLR_n from checker; active-low clear.
REQ-005 Pin2  input  1  chip CLK from checker; asynchronous to Clk.
REQ-006 Pin3, Pin4, Pin5, Pin6  input  1 each  parallel data A, B, C, D (A = LSB).
REQ-007 Pin7  input  1  ENP, count enable P.
REQ-008 Pin9  input  1  LOAD_n; active-low parallel load.
REQ-009 Pin10  input  1  ENT, count enable T.
REQ-010 Pin14, Pin13, Pin12, Pin11  output  1 each  QA, QB, QC, QD (QA = LSB).
REQ-011 Pin15  output  1  RCO, ripple carry out.
REQ-012 Fault_Sel  input  2  injected fault: 00 none, 01 QB stuck-0, 10 RCO stuck-0, 11 count by 2.

Function
REQ-013 SHALL pass each of Pin1-Pin7, Pin9 and Pin10 through its own 2-flop synchronizer (s1, s2) clocked by Clk.
REQ-014 SHALL hold prev = s2 of Pin2 each cycle; pin_edge = s2 & ~prev & warm_done.
REQ-015 SHALL hold a 2-bit warm-up counter: 0 at reset, saturating at 2; warm_done = (counter == 2).
REQ-016 SHALL hold a 4-bit state register Q; the pins QA..QD SHALL be driven from Q, with the fault override of REQ-021 applied.
REQ-017 Q update priority on each Clk edge, all decisions on synchronized values:
  - CLR_n = 0: Q <- 0 regardless of pin_edge (level-sensitive clear, as on the real part).
  - else pin_edge and LOAD_n = 0: Q <- {D,C,B,A}.
  - else pin_edge, ENP = 1 and ENT = 1: Q <- Q + step mod 16; step = 2 if Fault_Sel = 11, else 1.
  - otherwise: hold.
REQ-018 The 4-bit wrap SHALL be silent: 1111 + 1 gives 0000; 1111 + 2 gives 0001; 1110 + 2 gives 0000.
REQ-019 Latency: a Pin2 rise that meets setup before Clk edge k SHALL update Q at edge k+2.
  - The load/enable inputs that apply are those sampled at edge k.
  - A CLR_n fall before edge k SHALL zero Q at edge k+2.
REQ-020 RCO SHALL equal synchronized ENT AND (Q == 1111); it is registered-output logic with no extra latency beyond Q and the synchronizer.
REQ-021 Fault overrides SHALL act on outputs only, except count-by-2, which acts on the Q update:
  - 01: Pin13 = 0.
  - 10: Pin15 = 0.
  - Fault_Sel SHALL be sampled directly, with no synchronizer.
REQ-022 Simultaneous CLR_n low and LOAD_n low with pin_edge SHALL clear; LOAD_n low with ENP = ENT = 1 SHALL load.
REQ-023 Pin2 pulses shorter than 2 Clk periods high or low MAY be missed; the block SHALL never produce more than one update per synchronized rising edge.

Reset
REQ-024 While Reset = 0:
  - Q = 0000; all synchronizer flops, prev and the warm-up counter = 0.
  - Pin11-Pin14 = 0 and Pin15 = 0, regardless of any other input.
REQ-025 Reset assertion mid-count SHALL take effect immediately, without a Clk edge.
REQ-026 No pin_edge SHALL occur within the first 2 Clk edges after Reset rises, even if Pin2 is already high.

Verification
REQ-027 Reset pulse with Pin2 toggling and Q = 0101 -> outputs 0000 and RCO 0 immediately; then release with Pin2 held high, CLR_n = 1, ENP = ENT = 1 -> Q stays 0000 for 10 cycles.
REQ-028 CLR_n = 1, LOAD_n = 0, DCBA = 1010, one Pin2 rise before edge k -> Q = 1010 at edge k+2, not before.
REQ-029 From Q = 0, ENP = ENT = 1, 15 Pin2 rises -> Q = 1111, RCO = 1; 16th rise -> Q = 0000, RCO = 0.
REQ-030 At Q = 1111 with ENP = 0 and ENT = 1, Pin2 rises -> Q holds and RCO = 1; then drop ENT -> RCO = 0 two edges later.
REQ-031 Q = 0111, CLR_n and LOAD_n both low, with and without a Pin2 rise -> Q = 0000 at edge k+2.
REQ-032 Fault_Sel = 11 from Q = 0 with 3 rises -> Q = 0110; Fault_Sel = 01 at Q = 0010 -> Pin13 = 0; Fault_Sel = 10 at Q = 1111 with ENT = 1 -> RCO = 0.

Source files
------------

// File: rtl/chip_74161_emu.sv
// chip_74161_emu
//   Emulates a 74161 4-bit synchronous binary counter. The checker drives the
//   chip pins asynchronously to the system clock. Each pin is synchronized,
//   and a rising edge on the chip clock (Pin2) is detected in the Clk domain.
//   A selectable fault can be injected so the checker has known-bad parts.
//
// Ports
//   Clk        system clock; all state updates on its rising edge
//   Reset      asynchronous active-low reset
//   Pin1       CLR_n, active-low clear (level-sensitive)
//   Pin2       chip CLK from the checker
//   Pin3..Pin6 parallel data A, B, C, D (A = LSB)
//   Pin7       ENP, count enable P
//   Pin9       LOAD_n, active-low parallel load
//   Pin10      ENT, count enable T (also gates RCO)
//   Pin14..11  QA, QB, QC, QD outputs (QA = LSB)
//   Pin15      RCO, ripple carry out
//   Fault_Sel  00 none, 01 QB stuck-0, 10 RCO stuck-0, 11 count by 2
module chip_74161_emu (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pin1,
  input  logic       Pin2,
  input  logic       Pin3,
  input  logic       Pin4,
  input  logic       Pin5,
  input  logic       Pin6,
  input  logic       Pin7,
  input  logic       Pin9,
  input  logic       Pin10,
  input  logic [1:0] Fault_Sel,
  output logic       Pin11,
  output logic       Pin12,
  output logic       Pin13,
  output logic       Pin14,
  output logic       Pin15
);

  // Bit positions inside the synchronizer vectors.
  localparam int unsigned B_CLR  = 0;
  localparam int unsigned B_CLK  = 1;
  localparam int unsigned B_DA   = 2;
  localparam int unsigned B_DD   = 5;
  localparam int unsigned B_ENP  = 6;
  localparam int unsigned B_LOAD = 7;
  localparam int unsigned B_ENT  = 8;

  localparam logic [1:0] FAULT_QB_LOW  = 2'b01;
  localparam logic [1:0] FAULT_RCO_LOW = 2'b10;
  localparam logic [1:0] FAULT_STEP2   = 2'b11;

  logic [8:0] pins_raw;
  logic [8:0] sync1;
  logic [8:0] sync2;
  logic       prev;
  logic       armed;
  logic [1:0] warm_cnt;
  logic       warm_done;
  logic       pin_edge;
  logic [3:0] q;
  logic [3:0] q_next;
  logic [3:0] step;

  assign pins_raw = {Pin10, Pin9, Pin7, Pin6, Pin5, Pin4, Pin3, Pin2, Pin1};

  // The warm-up count only starts on the second edge after reset so that
  // warm_done rises after prev has caught up with sync2; a Pin2 held high
  // through reset release therefore never looks like a rising edge.
  assign warm_done = (warm_cnt == 2'd2);
  assign pin_edge  = sync2[B_CLK] & ~prev & warm_done;

  always_comb begin
    step   = (Fault_Sel == FAULT_STEP2) ? 4'd2 : 4'd1;
    q_next = q;
    if (!sync2[B_CLR]) begin
      q_next = '0;
    end else if (pin_edge && !sync2[B_LOAD]) begin
      q_next = sync2[B_DD:B_DA];
    end else if (pin_edge && sync2[B_ENP] && sync2[B_ENT]) begin
      q_next = q + step;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync1    <= '0;
      sync2    <= '0;
      prev     <= 1'b0;
      armed    <= 1'b0;
      warm_cnt <= '0;
      q        <= '0;
    end else begin
      sync1 <= pins_raw;
      sync2 <= sync1;
      prev  <= sync2[B_CLK];
      armed <= 1'b1;
      if (armed && !warm_done) begin
        warm_cnt <= warm_cnt + 2'd1;
      end
      q <= q_next;
    end
  end

  always_comb begin
    Pin14 = q[0];
    Pin13 = q[1] & (Fault_Sel != FAULT_QB_LOW);
    Pin12 = q[2];
    Pin11 = q[3];
    Pin15 = sync2[B_ENT] & (&q) & (Fault_Sel != FAULT_RCO_LOW);
  end

endmodule

// File: tb/tb_chip_74161_emu.sv
// Directed bench for chip_74161_emu. Inputs change and outputs are sampled on
// the falling edge of Clk; the DUT acts on the rising edge.
module tb_chip_74161_emu;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Pin1 = 1'b1;
  logic       Pin2 = 1'b0;
  logic       Pin3 = 1'b0;
  logic       Pin4 = 1'b0;
  logic       Pin5 = 1'b0;
  logic       Pin6 = 1'b0;
  logic       Pin7 = 1'b0;
  logic       Pin9 = 1'b1;
  logic       Pin10 = 1'b0;
  logic [1:0] Fault_Sel = 2'b00;
  logic       Pin11, Pin12, Pin13, Pin14, Pin15;
  logic [3:0] q_out;

  int tests = 0;
  int fails = 0;

  chip_74161_emu dut (
    .Clk(Clk), .Reset(Reset),
    .Pin1(Pin1), .Pin2(Pin2), .Pin3(Pin3), .Pin4(Pin4), .Pin5(Pin5),
    .Pin6(Pin6), .Pin7(Pin7), .Pin9(Pin9), .Pin10(Pin10),
    .Fault_Sel(Fault_Sel),
    .Pin11(Pin11), .Pin12(Pin12), .Pin13(Pin13), .Pin14(Pin14), .Pin15(Pin15)
  );

  always #5 Clk = ~Clk;

  assign q_out = {Pin11, Pin12, Pin13, Pin14};

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One clean chip-clock pulse: high 3 cycles, low 3 cycles. The rise is
  // applied before edge k, so Q has its new value after edge k+2.
  task automatic rise();
    Pin2 = 1'b1;
    tick(3);
    Pin2 = 1'b0;
    tick(3);
  endtask

  task automatic load_val(input logic [3:0] v);
    {Pin6, Pin5, Pin4, Pin3} = v;
    Pin9 = 1'b0;
    rise();
    Pin9 = 1'b1;
  endtask

  task automatic clear_q();
    Pin1 = 1'b0;
    tick(3);
    Pin1 = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    tick(1);
    Pin2 = 1'b1;
    tick(1);
    Pin2 = 1'b0;
    tick(1);
    tests++;
    if (q_out !== 4'b0000 || Pin15 !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold q=%b rco=%b exp q=0000 rco=0", q_out, Pin15);
    end
    Reset = 1'b1;
    tick(4);
    Pin7 = 1'b0; Pin10 = 1'b0;
    load_val(4'b0101);
    tests++;
    if (q_out !== 4'b0101) begin
      fails++;
      $display("FAIL preload_0101 q=%b exp=0101", q_out);
    end
    // Assert reset mid-cycle with Pin2 toggling; no Clk edge in between.
    Pin2 = 1'b1;
    tick(1);
    Pin2 = 1'b0;
    #2 Reset = 1'b0;
    #1;
    tests++;
    if (q_out !== 4'b0000 || Pin15 !== 1'b0) begin
      fails++;
      $display("FAIL reset_async q=%b rco=%b exp q=0000 rco=0", q_out, Pin15);
    end
    @(negedge Clk);
    Pin2 = 1'b1; Pin1 = 1'b1; Pin7 = 1'b1; Pin10 = 1'b1; Pin9 = 1'b1;
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      tests++;
      if (q_out !== 4'b0000) begin
        fails++;
        $display("FAIL warmup_no_edge cycle=%0d q=%b exp=0000", i, q_out);
      end
    end
    Pin2 = 1'b0;
    tick(3);
  endtask

  task automatic test_load();
    Pin7 = 1'b1; Pin10 = 1'b1;
    {Pin6, Pin5, Pin4, Pin3} = 4'b1010;
    Pin9 = 1'b0;
    Pin2 = 1'b1;
    tick(1);
    tests++;
    if (q_out !== 4'b0000) begin
      fails++;
      $display("FAIL load_edge_k q=%b exp=0000", q_out);
    end
    tick(1);
    tests++;
    if (q_out !== 4'b0000) begin
      fails++;
      $display("FAIL load_edge_k1 q=%b exp=0000", q_out);
    end
    tick(1);
    tests++;
    if (q_out !== 4'b1010) begin
      fails++;
      $display("FAIL load_edge_k2 q=%b exp=1010", q_out);
    end
    Pin2 = 1'b0;
    Pin9 = 1'b1;
    tick(3);
  endtask

  task automatic test_count_wrap();
    clear_q();
    Pin7 = 1'b1; Pin10 = 1'b1;
    for (int i = 0; i < 5; i++) rise();
    tests++;
    if (q_out !== 4'b0101) begin
      fails++;
      $display("FAIL count_5 q=%b exp=0101", q_out);
    end
    for (int i = 0; i < 10; i++) rise();
    tests++;
    if (q_out !== 4'b1111 || Pin15 !== 1'b1) begin
      fails++;
      $display("FAIL count_15 q=%b rco=%b exp q=1111 rco=1", q_out, Pin15);
    end
    rise();
    tests++;
    if (q_out !== 4'b0000 || Pin15 !== 1'b0) begin
      fails++;
      $display("FAIL count_wrap q=%b rco=%b exp q=0000 rco=0", q_out, Pin15);
    end
  endtask

  task automatic test_hold_rco();
    load_val(4'b1111);
    Pin7 = 1'b0; Pin10 = 1'b1;
    rise();
    tests++;
    if (q_out !== 4'b1111 || Pin15 !== 1'b1) begin
      fails++;
      $display("FAIL hold_enp0 q=%b rco=%b exp q=1111 rco=1", q_out, Pin15);
    end
    Pin10 = 1'b0;
    tick(1);
    tests++;
    if (Pin15 !== 1'b1) begin
      fails++;
      $display("FAIL rco_ent_edge1 rco=%b exp=1", Pin15);
    end
    tick(1);
    tests++;
    if (Pin15 !== 1'b0) begin
      fails++;
      $display("FAIL rco_ent_edge2 rco=%b exp=0", Pin15);
    end
    Pin7 = 1'b1;
    rise();
    tests++;
    if (q_out !== 4'b1111) begin
      fails++;
      $display("FAIL hold_ent0 q=%b exp=1111", q_out);
    end
  endtask

  task automatic test_clear_priority();
    Pin7 = 1'b1; Pin10 = 1'b1;
    load_val(4'b0111);
    {Pin6, Pin5, Pin4, Pin3} = 4'b1001;
    Pin1 = 1'b0; Pin9 = 1'b0; Pin2 = 1'b1;
    tick(2);
    tests++;
    if (q_out !== 4'b0111) begin
      fails++;
      $display("FAIL clr_load_edge_k1 q=%b exp=0111", q_out);
    end
    tick(1);
    tests++;
    if (q_out !== 4'b0000) begin
      fails++;
      $display("FAIL clr_load_edge_k2 q=%b exp=0000", q_out);
    end
    Pin2 = 1'b0; Pin1 = 1'b1; Pin9 = 1'b1;
    tick(3);
    load_val(4'b0111);
    Pin1 = 1'b0; Pin9 = 1'b0;
    tick(2);
    tests++;
    if (q_out !== 4'b0111) begin
      fails++;
      $display("FAIL clr_noedge_k1 q=%b exp=0111", q_out);
    end
    tick(1);
    tests++;
    if (q_out !== 4'b0000) begin
      fails++;
      $display("FAIL clr_noedge_k2 q=%b exp=0000", q_out);
    end
    Pin1 = 1'b1; Pin9 = 1'b1;
    tick(3);
  endtask

  task automatic test_faults();
    clear_q();
    Pin7 = 1'b1; Pin10 = 1'b1;
    Fault_Sel = 2'b11;
    for (int i = 0; i < 3; i++) rise();
    tests++;
    if (q_out !== 4'b0110) begin
      fails++;
      $display("FAIL step2_x3 q=%b exp=0110", q_out);
    end
    load_val(4'b1110);
    rise();
    tests++;
    if (q_out !== 4'b0000) begin
      fails++;
      $display("FAIL step2_wrap_1110 q=%b exp=0000", q_out);
    end
    load_val(4'b1111);
    rise();
    tests++;
    if (q_out !== 4'b0001) begin
      fails++;
      $display("FAIL step2_wrap_1111 q=%b exp=0001", q_out);
    end
    Fault_Sel = 2'b00;
    load_val(4'b0010);
    Fault_Sel = 2'b01;
    #1;
    tests++;
    if (Pin13 !== 1'b0 || q_out !== 4'b0000) begin
      fails++;
      $display("FAIL qb_stuck q=%b exp=0000", q_out);
    end
    Fault_Sel = 2'b00;
    #1;
    tests++;
    if (q_out !== 4'b0010) begin
      fails++;
      $display("FAIL qb_released q=%b exp=0010", q_out);
    end
    Pin7 = 1'b0;
    load_val(4'b1111);
    Fault_Sel = 2'b10;
    #1;
    tests++;
    if (Pin15 !== 1'b0 || q_out !== 4'b1111) begin
      fails++;
      $display("FAIL rco_stuck rco=%b q=%b exp rco=0 q=1111", Pin15, q_out);
    end
    Fault_Sel = 2'b00;
    #1;
    tests++;
    if (Pin15 !== 1'b1) begin
      fails++;
      $display("FAIL rco_released rco=%b exp=1", Pin15);
    end
    tick(1);
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_load();
    test_count_wrap();
    test_hold_rco();
    test_clear_priority();
    test_faults();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
